activation_unit: RTL and testbench

Parametrised pipelined activation stage for the neuron datapath. It generalises the sigmoid unit to configurable argument, result and error widths, and offers a choice of sigmoid or clamped ReLU. Forward and backward channels are decoupled: a derivative history FIFO of depth DEPTH lets several forward passes run before their errors return. It sits between a neuron accumulator (argument/error side) and the next layer (result/propagate side).

---
 rtl/activation_unit.sv | 264 ++++++++++++++++++++++++++
 tb/tb_activation_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_unit.sv
// activation_unit: pipelined sigmoid / clamped-ReLU activation stage.
// The forward path registers f(argument) with one cycle of latency. The
// derivative of each trained forward pass is kept in a small history FIFO
// until its error comes back. The backward path scales that error by the
// derivative and registers the product with one cycle of latency.
module activation_unit #(
  parameter int  ARG_WIDTH = 16,
  parameter int  FRAC      = 8,
  parameter int  RES_WIDTH = 8,
  parameter int  ERR_WIDTH = 16,
  parameter int  KIND      = 0,
  parameter int  LIMIT     = 6,
  parameter real RATE      = 1.0,
  parameter int  DEPTH     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         train,
  input  logic                         argument_valid,
  output logic                         argument_ready,
  input  logic [ARG_WIDTH-1:0]         argument_data,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [RES_WIDTH-1:0]         result_data,
  input  logic                         error_valid,
  output logic                         error_ready,
  input  logic [ERR_WIDTH-1:0]         error_data,
  output logic                         propagate_valid,
  input  logic                         propagate_ready,
  output logic [ERR_WIDTH-1:0]         propagate_data,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int PW    = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DW    = RES_WIDTH + 1;
  localparam int RMAX  = (1 << RES_WIDTH) - 1;
  localparam int PRODW = ERR_WIDTH + DW + 1;

  localparam logic [RES_WIDTH-1:0] RES_MAX = '1;
  localparam logic [DW-1:0]        ONE     = DW'(1 << RES_WIDTH);
  localparam logic [PW-1:0]        FULL    = PW'(DEPTH);
  localparam logic [AW-1:0]        LAST    = AW'(DEPTH - 1);

  // exp(y) by halving the argument into a small range, a Taylor series, and
  // repeated squaring; evaluated only while building the LUT.
  function automatic real exp_approx(input real y);
    real         v;
    real         term;
    real         sum;
    int unsigned halvings;
    v        = y;
    halvings = 0;
    while ((v > 0.125 || v < -0.125) && halvings < 64) begin
      v        = v / 2.0;
      halvings = halvings + 1;
    end
    sum  = 1.0;
    term = 1.0;
    for (int unsigned k = 1; k <= 14; k++) begin
      term = term * v / real'(k);
      sum  = sum + term;
    end
    for (int unsigned k = 0; k < halvings; k++) begin
      sum = sum * sum;
    end
    return sum;
  endfunction

  // One sigmoid LUT entry: floor(2^RES_WIDTH * f(x)), capped at full scale.
  function automatic int sig_entry(input int idx, input int bound);
    real x;
    real f;
    real scaled;
    int  e;
    x      = real'(idx - bound) / real'(1 << FRAC);
    f      = 1.0 / (1.0 + exp_approx(-RATE * x));
    scaled = f * real'(1 << RES_WIDTH);
    e      = $rtoi(scaled);
    if (e > RMAX) e = RMAX;
    if (e < 0)    e = 0;
    return e;
  endfunction

  // Forward function outputs for the argument currently offered.
  logic [RES_WIDTH-1:0] fwd_res;
  logic [DW-1:0]        fwd_der;

  generate
    if (KIND == 0) begin : g_sigmoid
      localparam int BOUND = LIMIT << FRAC;
      localparam int LUT_N = 2 * BOUND;
      localparam int IW    = (LUT_N > 1) ? $clog2(LUT_N) : 1;

      logic [RES_WIDTH-1:0] lut [LUT_N];
      logic signed [31:0]   arg_s;
      logic signed [31:0]   idx_s;
      logic [DW-1:0]        r_ext;
      logic [DW-1:0]        r_comp;
      logic [2*DW-1:0]      der_prod;

      for (genvar i = 0; i < LUT_N; i++) begin : g_lut
        localparam logic [RES_WIDTH-1:0] ENTRY = RES_WIDTH'(sig_entry(i, BOUND));
        assign lut[i] = ENTRY;
      end

      // Saturate outside +-LIMIT, otherwise look up; derivative is r*(1-r).
      always_comb begin
        arg_s   = 32'($signed(argument_data));
        idx_s   = arg_s + BOUND;
        fwd_res = lut[IW'(idx_s)];
        if (arg_s >= BOUND) begin
          fwd_res = RES_MAX;
        end else if (arg_s < -BOUND) begin
          fwd_res = '0;
        end
        r_ext    = {1'b0, fwd_res};
        r_comp   = ONE - r_ext;
        der_prod = {{DW{1'b0}}, r_ext} * {{DW{1'b0}}, r_comp};
        fwd_der  = DW'(der_prod >> RES_WIDTH);
      end
    end else begin : g_relu
      localparam int SHIFT = FRAC - RES_WIDTH;

      logic signed [ARG_WIDTH-1:0] s;

      // Rescale to result units, clamp to [0, full scale]; slope 1 inside.
      always_comb begin
        s       = $signed(argument_data) >>> SHIFT;
        fwd_res = s[RES_WIDTH-1:0];
        fwd_der = ONE;
        if (s < 0) begin
          fwd_res = '0;
          fwd_der = '0;
        end else if (s > RMAX) begin
          fwd_res = RES_MAX;
          fwd_der = '0;
        end
      end
    end
  endgenerate

  // Forward output register and handshake
  logic                 result_valid_q, result_valid_d;
  logic [RES_WIDTH-1:0] result_data_q,  result_data_d;
  logic                 arg_fire;
  logic                 push;

  // Backward output register and handshake
  logic                 propagate_valid_q, propagate_valid_d;
  logic [ERR_WIDTH-1:0] propagate_data_q,  propagate_data_d;
  logic                 err_fire;
  logic                 pop;

  // Derivative history FIFO
  logic [DW-1:0]        fifo_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        count_q,  count_d;
  logic [DW-1:0]        head;

  logic [PRODW-1:0]        bw_err_ext;
  logic [PRODW-1:0]        bw_der_ext;
  logic signed [PRODW-1:0] bw_prod;
  logic [ERR_WIDTH-1:0]    bw_res;

  // A full FIFO blocks a trained push even when a pop lands in the same cycle.
  always_comb begin
    argument_ready = (!result_valid_q | result_ready) & !(train & (count_q == FULL));
    arg_fire       = argument_valid & argument_ready;
    push           = arg_fire & train;
    error_ready    = (count_q != '0) & (!propagate_valid_q | propagate_ready);
    err_fire       = error_valid & error_ready;
    pop            = err_fire;
  end

  // Forward register next state: load on accept, drop valid once taken.
  always_comb begin
    result_valid_d = result_valid_q;
    result_data_d  = result_data_q;
    if (arg_fire) begin
      result_valid_d = 1'b1;
      result_data_d  = fwd_res;
    end else if (result_ready) begin
      result_valid_d = 1'b0;
    end
  end

  // Backward product: error times unsigned derivative, floor-shifted by RES_WIDTH.
  always_comb begin
    head       = fifo_q[rd_ptr_q];
    bw_err_ext = {{(DW + 1){error_data[ERR_WIDTH-1]}}, error_data};
    bw_der_ext = {{(ERR_WIDTH + 1){1'b0}}, head};
    bw_prod    = $signed(bw_err_ext * bw_der_ext);
    bw_res     = ERR_WIDTH'(bw_prod >>> RES_WIDTH);
  end

  // Backward register next state: load on accept, drop valid once taken.
  always_comb begin
    propagate_valid_d = propagate_valid_q;
    propagate_data_d  = propagate_data_q;
    if (err_fire) begin
      propagate_valid_d = 1'b1;
      propagate_data_d  = bw_res;
    end else if (propagate_ready) begin
      propagate_valid_d = 1'b0;
    end
  end

  // FIFO pointer and occupancy next state; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pipeline and FIFO state; reset discards everything in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_valid_q    <= 1'b0;
      result_data_q     <= '0;
      propagate_valid_q <= 1'b0;
      propagate_data_q  <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      result_valid_q    <= result_valid_d;
      result_data_q     <= result_data_d;
      propagate_valid_q <= propagate_valid_d;
      propagate_data_q  <= propagate_data_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= fwd_der;
      end
    end
  end

  // Registered outputs
  always_comb begin
    result_valid    = result_valid_q;
    result_data     = result_data_q;
    propagate_valid = propagate_valid_q;
    propagate_data  = propagate_data_q;
    pending         = count_q;
  end

endmodule

// File: tb/tb_activation_unit.sv
// Bench for activation_unit: a sigmoid instance and a ReLU instance share all
// inputs; a transaction-level model (real-valued functions plus a queue of
// derivatives) predicts readies, results, propagates and occupancy.
module tb_activation_unit;

  localparam int DEPTH = 4;
  localparam int RW    = 8;
  localparam int FRAC  = 8;
  localparam int LIMIT = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        train = 1'b0;
  logic        argument_valid = 1'b0;
  logic [15:0] argument_data = '0;
  logic        result_ready = 1'b0;
  logic        error_valid = 1'b0;
  logic [15:0] error_data = '0;
  logic        propagate_ready = 1'b0;

  logic [1:0]  ar, rv, er, pv;
  logic [7:0]  rd   [2];
  logic [15:0] pd   [2];
  logic [2:0]  pend [2];

  activation_unit #(.ARG_WIDTH(16), .FRAC(FRAC), .RES_WIDTH(RW), .ERR_WIDTH(16),
                    .KIND(0), .LIMIT(LIMIT), .RATE(1.0), .DEPTH(DEPTH)) u_sig (
    .clock(clock), .reset(reset), .train(train),
    .argument_valid(argument_valid), .argument_ready(ar[0]), .argument_data(argument_data),
    .result_valid(rv[0]), .result_ready(result_ready), .result_data(rd[0]),
    .error_valid(error_valid), .error_ready(er[0]), .error_data(error_data),
    .propagate_valid(pv[0]), .propagate_ready(propagate_ready), .propagate_data(pd[0]),
    .pending(pend[0]));

  activation_unit #(.ARG_WIDTH(16), .FRAC(FRAC), .RES_WIDTH(RW), .ERR_WIDTH(16),
                    .KIND(1), .LIMIT(LIMIT), .RATE(1.0), .DEPTH(DEPTH)) u_relu (
    .clock(clock), .reset(reset), .train(train),
    .argument_valid(argument_valid), .argument_ready(ar[1]), .argument_data(argument_data),
    .result_valid(rv[1]), .result_ready(result_ready), .result_data(rd[1]),
    .error_valid(error_valid), .error_ready(er[1]), .error_data(error_data),
    .propagate_valid(pv[1]), .propagate_ready(propagate_ready), .propagate_data(pd[1]),
    .pending(pend[1]));

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  bit          m_rv, m_pv;
  logic [7:0]  m_rd [2];
  logic [15:0] m_pd [2];
  int          dq0[$];
  int          dq1[$];
  bit          x_ar, x_er, acc_a, acc_e;
  logic [1:0]  o_ar, o_er;

  function automatic int ref_result(input int kind, input logic [15:0] a_bits);
    int  a;
    int  s;
    int  v;
    real f;
    a = $signed(a_bits);
    if (kind == 0) begin
      if (a >= LIMIT * 256) return 255;
      if (a < -(LIMIT * 256)) return 0;
      f = 1.0 / (1.0 + $exp(-real'(a) / 256.0));
      v = $rtoi($floor(f * 256.0));
      return (v > 255) ? 255 : v;
    end
    s = $rtoi($floor(real'(a) / real'(1 << (FRAC - RW))));
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  function automatic int ref_deriv(input int kind, input logic [15:0] a_bits);
    int r;
    int s;
    if (kind == 0) begin
      r = ref_result(0, a_bits);
      return (r * (256 - r)) / 256;
    end
    s = $rtoi($floor(real'($signed(a_bits)) / real'(1 << (FRAC - RW))));
    return (s >= 0 && s <= 255) ? 256 : 0;
  endfunction

  function automatic logic [15:0] ref_prop(input logic [15:0] e_bits, input int d);
    int e;
    int p;
    e = $signed(e_bits);
    p = $rtoi($floor(real'(e) * real'(d) / 256.0));
    return 16'(p);
  endfunction

  task automatic model_reset();
    m_rv = 1'b0; m_pv = 1'b0;
    m_rd[0] = '0; m_rd[1] = '0;
    m_pd[0] = '0; m_pd[1] = '0;
    dq0.delete(); dq1.delete();
  endtask

  // One clock: predict readies before the edge, advance the model on it.
  task automatic step();
    int d0;
    int d1;
    @(negedge clock);
    x_ar  = (!m_rv || result_ready) && !(train && dq0.size() == DEPTH);
    x_er  = (dq0.size() != 0) && (!m_pv || propagate_ready);
    o_ar  = ar;
    o_er  = er;
    acc_a = argument_valid && x_ar;
    acc_e = error_valid && x_er;
    @(posedge clock);
    if (acc_e) begin
      d0 = dq0.pop_front();
      d1 = dq1.pop_front();
      m_pv = 1'b1;
      m_pd[0] = ref_prop(error_data, d0);
      m_pd[1] = ref_prop(error_data, d1);
    end else if (propagate_ready) begin
      m_pv = 1'b0;
    end
    if (acc_a) begin
      m_rv = 1'b1;
      m_rd[0] = 8'(ref_result(0, argument_data));
      m_rd[1] = 8'(ref_result(1, argument_data));
      if (train) begin
        dq0.push_back(ref_deriv(0, argument_data));
        dq1.push_back(ref_deriv(1, argument_data));
      end
    end else if (result_ready) begin
      m_rv = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    train = 1'b0; argument_valid = 1'b0; error_valid = 1'b0;
    result_ready = 1'b0; propagate_ready = 1'b0;
    argument_data = '0; error_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (rv[k] !== 1'b0) begin n_bad++; $display("FAIL reset_rv[%0d]: got %b want 0", k, rv[k]); end
      n_cmp++; if (rd[k] !== 8'h00) begin n_bad++; $display("FAIL reset_rd[%0d]: got %h want 00", k, rd[k]); end
      n_cmp++; if (pv[k] !== 1'b0) begin n_bad++; $display("FAIL reset_pv[%0d]: got %b want 0", k, pv[k]); end
      n_cmp++; if (pd[k] !== 16'h0000) begin n_bad++; $display("FAIL reset_pd[%0d]: got %h want 0000", k, pd[k]); end
      n_cmp++; if (pend[k] !== 3'd0) begin n_bad++; $display("FAIL reset_pending[%0d]: got %0d want 0", k, pend[k]); end
    end
    reset = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (er[k] !== 1'b0) begin n_bad++; $display("FAIL reset_er[%0d]: got %b want 0", k, er[k]); end
      n_cmp++; if (ar[k] !== 1'b1) begin n_bad++; $display("FAIL reset_ar[%0d]: got %b want 1", k, ar[k]); end
    end
  endtask

  task automatic test_sigmoid_vectors();
    logic [15:0] args [4];
    logic [7:0]  want0 [4];
    logic [7:0]  want1 [4];
    args  = '{16'h0000, 16'h0600, 16'hFA00, 16'h8000};
    want0 = '{8'd128, 8'd255, 8'd0, 8'd0};
    want1 = '{8'd0, 8'd255, 8'd0, 8'd0};
    do_reset();
    train = 1'b1; result_ready = 1'b1; propagate_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      argument_valid = 1'b1;
      argument_data  = args[i];
      step();
      n_cmp++; if (o_ar[0] !== 1'b1) begin n_bad++; $display("FAIL vec_ready[%0d]: got %b want 1", i, o_ar[0]); end
      n_cmp++; if (rv[0] !== 1'b1) begin n_bad++; $display("FAIL vec_rv[%0d]: got %b want 1", i, rv[0]); end
      n_cmp++; if (rd[0] !== want0[i]) begin n_bad++; $display("FAIL vec_sig[%0d]: got %0d want %0d", i, rd[0], want0[i]); end
      n_cmp++; if (rd[1] !== want1[i]) begin n_bad++; $display("FAIL vec_relu[%0d]: got %0d want %0d", i, rd[1], want1[i]); end
    end
    argument_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (pend[k] !== 3'd4) begin n_bad++; $display("FAIL vec_pending[%0d]: got %0d want 4", k, pend[k]); end
    end
    step();
    n_cmp++; if (rv[0] !== 1'b0) begin n_bad++; $display("FAIL vec_rv_drop: got %b want 0", rv[0]); end
  endtask

  task automatic test_backward();
    logic [15:0] errs  [2];
    logic [15:0] want0 [2];
    errs  = '{16'h0100, 16'hFF00};
    want0 = '{16'h0040, 16'hFFC0};
    do_reset();
    train = 1'b1; result_ready = 1'b1; propagate_ready = 1'b1;
    argument_valid = 1'b1; argument_data = 16'h0000;
    step(); step();
    argument_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      error_valid = 1'b1; error_data = errs[i];
      step();
      n_cmp++; if (pv[0] !== 1'b1) begin n_bad++; $display("FAIL bwd_pv[%0d]: got %b want 1", i, pv[0]); end
      n_cmp++; if (pd[0] !== want0[i]) begin n_bad++; $display("FAIL bwd_sig[%0d]: got %h want %h", i, pd[0], want0[i]); end
      n_cmp++; if (pd[1] !== errs[i]) begin n_bad++; $display("FAIL bwd_relu[%0d]: got %h want %h", i, pd[1], errs[i]); end
    end
    error_valid = 1'b0;
    #1;
    n_cmp++; if (er[0] !== 1'b0) begin n_bad++; $display("FAIL bwd_empty_er: got %b want 0", er[0]); end
    n_cmp++; if (pend[0] !== 3'd0) begin n_bad++; $display("FAIL bwd_empty_pending: got %0d want 0", pend[0]); end
  endtask

  task automatic test_relu();
    logic [15:0] args  [4];
    logic [7:0]  want1 [4];
    logic [15:0] wantp [4];
    args  = '{16'h0080, 16'h00FF, 16'h0100, 16'hFFFB};
    want1 = '{8'd128, 8'd255, 8'd255, 8'd0};
    wantp = '{16'h1234, 16'h1234, 16'h0000, 16'h0000};
    do_reset();
    train = 1'b1; result_ready = 1'b1; propagate_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      argument_valid = 1'b1; argument_data = args[i];
      step();
      n_cmp++; if (rd[1] !== want1[i]) begin n_bad++; $display("FAIL relu_res[%0d]: got %0d want %0d", i, rd[1], want1[i]); end
      n_cmp++; if (rd[0] !== m_rd[0]) begin n_bad++; $display("FAIL relu_sigres[%0d]: got %0d want %0d", i, rd[0], m_rd[0]); end
    end
    argument_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      error_valid = 1'b1; error_data = 16'h1234;
      step();
      n_cmp++; if (pd[1] !== wantp[i]) begin n_bad++; $display("FAIL relu_prop[%0d]: got %h want %h", i, pd[1], wantp[i]); end
      n_cmp++; if (pd[0] !== m_pd[0]) begin n_bad++; $display("FAIL relu_sigprop[%0d]: got %h want %h", i, pd[0], m_pd[0]); end
    end
    error_valid = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    train = 1'b1; result_ready = 1'b1; propagate_ready = 1'b1;
    argument_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      argument_data = 16'($urandom_range(0, 3000)) - 16'd1500;
      step();
      n_cmp++; if (o_ar[0] !== x_ar) begin n_bad++; $display("FAIL full_ready[%0d]: got %b want %b", i, o_ar[0], x_ar); end
    end
    n_cmp++; if (ar[0] !== 1'b0) begin n_bad++; $display("FAIL full_blocked: got %b want 0", ar[0]); end
    n_cmp++; if (pend[0] !== 3'd4) begin n_bad++; $display("FAIL full_pending: got %0d want 4", pend[0]); end
    error_valid = 1'b1; error_data = 16'($urandom);
    step();
    n_cmp++; if (o_ar[0] !== 1'b0) begin n_bad++; $display("FAIL full_pop_cycle_ready: got %b want 0", o_ar[0]); end
    n_cmp++; if (o_er[0] !== 1'b1) begin n_bad++; $display("FAIL full_pop_er: got %b want 1", o_er[0]); end
    n_cmp++; if (pd[0] !== m_pd[0]) begin n_bad++; $display("FAIL full_pop_pd: got %h want %h", pd[0], m_pd[0]); end
    error_valid = 1'b0;
    step();
    n_cmp++; if (o_ar[0] !== 1'b1) begin n_bad++; $display("FAIL full_resume_ready: got %b want 1", o_ar[0]); end
    n_cmp++; if (rd[0] !== m_rd[0]) begin n_bad++; $display("FAIL full_resume_rd: got %0d want %0d", rd[0], m_rd[0]); end
    n_cmp++; if (pend[0] !== 3'd4) begin n_bad++; $display("FAIL full_resume_pending: got %0d want 4", pend[0]); end
  endtask

  task automatic test_train_off();
    train = 1'b0; result_ready = 1'b1; argument_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      argument_data = 16'($urandom);
      step();
      n_cmp++; if (o_ar[0] !== 1'b1) begin n_bad++; $display("FAIL notrain_ready[%0d]: got %b want 1", i, o_ar[0]); end
      n_cmp++; if (rd[0] !== m_rd[0]) begin n_bad++; $display("FAIL notrain_sig[%0d]: got %0d want %0d", i, rd[0], m_rd[0]); end
      n_cmp++; if (rd[1] !== m_rd[1]) begin n_bad++; $display("FAIL notrain_relu[%0d]: got %0d want %0d", i, rd[1], m_rd[1]); end
      n_cmp++; if (pend[1] !== 3'd4) begin n_bad++; $display("FAIL notrain_pending[%0d]: got %0d want 4", i, pend[1]); end
    end
    argument_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    train = 1'b1; result_ready = 1'b1; propagate_ready = 1'b1;
    argument_valid = 1'b1; argument_data = 16'($urandom);
    step();
    error_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      argument_data = 16'($urandom_range(0, 4000)) - 16'd2000;
      error_data    = 16'($urandom);
      step();
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (o_ar[k] !== 1'b1 || o_er[k] !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d][%0d]: got %b%b want 11", i, k, o_ar[k], o_er[k]); end
        n_cmp++; if (rv[k] !== 1'b1 || pv[k] !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d][%0d]: got %b%b want 11", i, k, rv[k], pv[k]); end
        n_cmp++; if (rd[k] !== m_rd[k]) begin n_bad++; $display("FAIL b2b_rd[%0d][%0d]: got %0d want %0d", i, k, rd[k], m_rd[k]); end
        n_cmp++; if (pd[k] !== m_pd[k]) begin n_bad++; $display("FAIL b2b_pd[%0d][%0d]: got %h want %h", i, k, pd[k], m_pd[k]); end
        n_cmp++; if (pend[k] !== 3'd1) begin n_bad++; $display("FAIL b2b_pending[%0d][%0d]: got %0d want 1", i, k, pend[k]); end
      end
    end
    argument_valid = 1'b0; error_valid = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      train           = ($urandom_range(0, 3) != 0);
      argument_valid  = ($urandom_range(0, 1) != 0);
      argument_data   = ($urandom_range(0, 2) == 0) ? 16'($urandom)
                                                    : 16'($urandom_range(0, 3600)) - 16'd1800;
      result_ready    = ($urandom_range(0, 9) < 7);
      error_valid     = ($urandom_range(0, 1) != 0);
      error_data      = 16'($urandom);
      propagate_ready = ($urandom_range(0, 9) < 7);
      step();
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (o_ar[k] !== x_ar) begin n_bad++; $display("FAIL rnd_ar[%0d][%0d]: got %b want %b", i, k, o_ar[k], x_ar); end
        n_cmp++; if (o_er[k] !== x_er) begin n_bad++; $display("FAIL rnd_er[%0d][%0d]: got %b want %b", i, k, o_er[k], x_er); end
        n_cmp++; if (rv[k] !== m_rv) begin n_bad++; $display("FAIL rnd_rv[%0d][%0d]: got %b want %b", i, k, rv[k], m_rv); end
        n_cmp++; if (pv[k] !== m_pv) begin n_bad++; $display("FAIL rnd_pv[%0d][%0d]: got %b want %b", i, k, pv[k], m_pv); end
        n_cmp++; if (rd[k] !== m_rd[k]) begin n_bad++; $display("FAIL rnd_rd[%0d][%0d]: got %0d want %0d", i, k, rd[k], m_rd[k]); end
        n_cmp++; if (pd[k] !== m_pd[k]) begin n_bad++; $display("FAIL rnd_pd[%0d][%0d]: got %h want %h", i, k, pd[k], m_pd[k]); end
        n_cmp++; if (pend[k] !== 3'(dq0.size())) begin n_bad++; $display("FAIL rnd_pending[%0d][%0d]: got %0d want %0d", i, k, pend[k], dq0.size()); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    train = 1'b1; result_ready = 1'b1; propagate_ready = 1'b1;
    argument_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      argument_data = 16'($urandom_range(0, 3000)) - 16'd1500;
      step();
    end
    argument_valid = 1'b0; result_ready = 1'b0;
    n_cmp++; if (rv[0] !== 1'b1) begin n_bad++; $display("FAIL mid_pre_rv: got %b want 1", rv[0]); end
    n_cmp++; if (pend[0] !== 3'd3) begin n_bad++; $display("FAIL mid_pre_pending: got %0d want 3", pend[0]); end
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (rv[k] !== 1'b0) begin n_bad++; $display("FAIL mid_rv[%0d]: got %b want 0", k, rv[k]); end
      n_cmp++; if (pv[k] !== 1'b0) begin n_bad++; $display("FAIL mid_pv[%0d]: got %b want 0", k, pv[k]); end
      n_cmp++; if (pend[k] !== 3'd0) begin n_bad++; $display("FAIL mid_pending[%0d]: got %0d want 0", k, pend[k]); end
      n_cmp++; if (rd[k] !== 8'h00) begin n_bad++; $display("FAIL mid_rd[%0d]: got %h want 00", k, rd[k]); end
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (er[k] !== 1'b0) begin n_bad++; $display("FAIL mid_release_er[%0d]: got %b want 0", k, er[k]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sigmoid_vectors();
    test_backward();
    test_relu();
    test_full();
    test_train_off();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule
